// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - UART-side and datapath-side signal bundle of the command parser
interface uart_cmd_parser_if #(
   parameter int DW = 8,
   parameter int NW = 4,
   parameter int CH = 2
);
   logic          rx_interrupt;
   logic [DW-1:0] uart_data;
   logic [CH-1:0] full;
   logic          busy;
   logic          clear_interrupt;
   logic [CH-1:0] push;
   logic [DW-1:0] push_data;
   logic [NW-1:0] n_size;
   logic          start;
   logic          retransmit;
   logic          clear;
   logic          frame_err;
   logic [1:0]    err_code;

   modport master (
      output rx_interrupt, uart_data, full, busy,
      input  clear_interrupt, push, push_data, n_size, start, retransmit, clear,
             frame_err, err_code
   );

   modport slave (
      input  rx_interrupt, uart_data, full, busy,
      output clear_interrupt, push, push_data, n_size, start, retransmit, clear,
             frame_err, err_code
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed UART command parser (FE LEN CMD payload EF)
// Drives push channels, the size register and control strobes; flags bad frames, overflow, timeout.
module uart_cmd_parser #(
   parameter int DW      = 8,
   parameter int NW      = 4,
   parameter int MAX_N   = 8,
   parameter int CH      = 2,
   parameter int TIMEOUT = 1023
) (
   input logic              clk,
   input logic              rst,
   uart_cmd_parser_if.slave bus
);
   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
   localparam logic [NW-1:0] N_MAX   = NW'(MAX_N);
   localparam logic [3:0]    CH_N    = 4'(CH);
   localparam logic [7:0]    SOF     = 8'hFE;
   localparam logic [7:0]    EOF     = 8'hEF;
   localparam logic [7:0]    C_SET_N = 8'h01;
   localparam logic [7:0]    C_RTX   = 8'h02;
   localparam logic [7:0]    C_START = 8'h03;
   localparam logic [7:0]    C_CLEAR = 8'h0F;

   typedef enum logic [2:0] {IDLE, GET_LEN, GET_CMD, GET_PAY, GET_END} state_t;
   state_t state, state_nx;

   logic [7:0]    remaining, remaining_nx, len_q, len_nx, cmd_q, cmd_nx;
   logic [NW-1:0] pay_q, pay_nx, n_size_q, n_size_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic          frame_bad, frame_bad_nx;
   logic [CH-1:0] push_q, push_nx, ch_sel;
   logic [DW-1:0] push_data_q, push_data_nx;
   logic          ack_q, start_q, start_nx, rtx_q, rtx_nx, clr_q, clr_nx;
   logic          ferr_q, ferr_nx;
   logic [1:0]    code_q, code_nx, err_val;
   logic          err_set, is_data, ch_full, cmd_ok;
   logic [7:0]    rx_byte;

   assign rx_byte = bus.uart_data[7:0];

   always_comb begin
      is_data = (cmd_q[7:4] == 4'h1) && (cmd_q[3:0] < CH_N);
      ch_sel  = '0;
      ch_full = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (cmd_q[3:0] == 4'(i)) begin
            ch_sel[i] = 1'b1;
            ch_full   = bus.full[i];
         end
      end
   end

   always_comb begin
      case (cmd_q)
         C_SET_N:        cmd_ok = (len_q == 8'd2) && (pay_q != '0) && (pay_q <= N_MAX);
         C_RTX, C_CLEAR: cmd_ok = (len_q == 8'd1);
         C_START:        cmd_ok = (len_q == 8'd1) && !bus.busy;
         default:        cmd_ok = is_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      len_nx       = len_q;
      cmd_nx       = cmd_q;
      pay_nx       = pay_q;
      n_size_nx    = n_size_q;
      tcnt_nx      = tcnt;
      frame_bad_nx = frame_bad;
      push_nx      = '0;
      push_data_nx = push_data_q;
      start_nx     = 1'b0;
      rtx_nx       = 1'b0;
      clr_nx       = 1'b0;
      ferr_nx      = ferr_q;
      code_nx      = code_q;
      err_set      = 1'b0;
      err_val      = 2'd0;

      // An arriving byte always reloads the idle counter, so it beats a same-cycle expiry.
      if (state == IDLE || bus.rx_interrupt) begin
         tcnt_nx = '0;
      end else if (tcnt == T_LAST) begin
         err_set  = 1'b1;
         err_val  = 2'd3;
         state_nx = IDLE;
         tcnt_nx  = '0;
      end else begin
         tcnt_nx = tcnt + 1'b1;
      end

      if (bus.rx_interrupt) begin
         case (state)
            IDLE: begin
               if (rx_byte == SOF) begin
                  state_nx     = GET_LEN;
                  frame_bad_nx = 1'b0;
               end
            end
            GET_LEN: begin
               if (rx_byte == 8'd0) begin
                  err_set  = 1'b1;
                  err_val  = 2'd1;
                  state_nx = IDLE;
               end else begin
                  len_nx       = rx_byte;
                  remaining_nx = rx_byte - 8'd1;
                  state_nx     = GET_CMD;
               end
            end
            GET_CMD: begin
               cmd_nx   = rx_byte;
               state_nx = (remaining != 8'd0) ? GET_PAY : GET_END;
            end
            GET_PAY: begin
               pay_nx       = rx_byte[NW-1:0];
               remaining_nx = remaining - 8'd1;
               if (remaining == 8'd1) state_nx = GET_END;
               if (is_data) begin
                  if (ch_full) begin
                     err_set = 1'b1;
                     err_val = 2'd2;
                  end else begin
                     push_nx      = ch_sel;
                     push_data_nx = bus.uart_data;
                  end
               end
            end
            GET_END: begin
               state_nx = IDLE;
               if (rx_byte == EOF && cmd_ok) begin
                  if (!frame_bad) ferr_nx = 1'b0;
                  if (cmd_q == C_SET_N) n_size_nx = pay_q;
                  start_nx = (cmd_q == C_START);
                  rtx_nx   = (cmd_q == C_RTX);
                  clr_nx   = (cmd_q == C_CLEAR);
               end else begin
                  err_set = 1'b1;
                  err_val = 2'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end

      if (err_set) begin
         ferr_nx      = 1'b1;
         code_nx      = err_val;
         frame_bad_nx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining   <= '0;
         len_q       <= '0;
         cmd_q       <= '0;
         pay_q       <= '0;
         n_size_q    <= NW'(1);
         tcnt        <= '0;
         frame_bad   <= 1'b0;
         push_q      <= '0;
         push_data_q <= '0;
         ack_q       <= 1'b0;
         start_q     <= 1'b0;
         rtx_q       <= 1'b0;
         clr_q       <= 1'b0;
         ferr_q      <= 1'b0;
         code_q      <= 2'd0;
      end else begin
         remaining   <= remaining_nx;
         len_q       <= len_nx;
         cmd_q       <= cmd_nx;
         pay_q       <= pay_nx;
         n_size_q    <= n_size_nx;
         tcnt        <= tcnt_nx;
         frame_bad   <= frame_bad_nx;
         push_q      <= push_nx;
         push_data_q <= push_data_nx;
         ack_q       <= bus.rx_interrupt;
         start_q     <= start_nx;
         rtx_q       <= rtx_nx;
         clr_q       <= clr_nx;
         ferr_q      <= ferr_nx;
         code_q      <= code_nx;
      end
   end

   assign bus.clear_interrupt = ack_q;
   assign bus.push            = push_q;
   assign bus.push_data       = push_data_q;
   assign bus.n_size          = n_size_q;
   assign bus.start           = start_q;
   assign bus.retransmit      = rtx_q;
   assign bus.clear           = clr_q;
   assign bus.frame_err       = ferr_q;
   assign bus.err_code        = code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - table, corner-case and randomized model check of uart_cmd_parser
module tb_uart_cmd_parser;
   localparam int DW = 8, NW = 4, MAX_N = 8, CH = 2, TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_cmd_parser_if #(.DW(DW), .NW(NW), .CH(CH)) bus ();
   uart_cmd_parser #(.DW(DW), .NW(NW), .MAX_N(MAX_N), .CH(CH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad = 0;
   int acks = 0, n_start = 0, n_rtx = 0, n_clr = 0, lat_err = 0;
   logic [CH+DW-1:0] pq[$];
   logic exp_ack = 1'b0;
   int a0, s0, r0, c0, p0;

   always @(posedge clk) exp_ack <= bus.rx_interrupt && !rst;

   always @(negedge clk) begin
      if (bus.clear_interrupt !== exp_ack) lat_err++;
      if (bus.push != '0 && !bus.clear_interrupt) lat_err++;
      if ($countones(bus.push) > 1) lat_err++;
      if (bus.clear_interrupt) acks++;
      if (bus.start) n_start++;
      if (bus.retransmit) n_rtx++;
      if (bus.clear) n_clr++;
      if (bus.push != '0) pq.push_back({bus.push, bus.push_data});
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [CH-1:0] f, input logic bz,
                            input int gap);
      bus.rx_interrupt = 1'b1;
      bus.uart_data    = b;
      bus.full         = f;
      bus.busy         = bz;
      @(posedge clk); #1;
      bus.rx_interrupt = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic mark();
      a0 = acks; s0 = n_start; r0 = n_rtx; c0 = n_clr; p0 = pq.size();
   endtask

   task automatic check_frame(input string nm, input logic [3:0] e_n, input logic e_ferr,
                              input logic [1:0] e_code, input int e_st, input int e_rt,
                              input int e_cl, input int e_acks, input int e_pu);
      repeat (2) begin @(posedge clk); #1; end
      check({nm, ".n_size"}, bus.n_size, e_n);
      check({nm, ".frame_err"}, bus.frame_err, e_ferr);
      check({nm, ".err_code"}, bus.err_code, e_code);
      check({nm, ".start"}, n_start - s0, e_st);
      check({nm, ".retransmit"}, n_rtx - r0, e_rt);
      check({nm, ".clear"}, n_clr - c0, e_cl);
      check({nm, ".acks"}, acks - a0, e_acks);
      check({nm, ".pushes"}, pq.size() - p0, e_pu);
   endtask

   task automatic check_reset(input string nm);
      check({nm, ".n_size"}, bus.n_size, 1);
      check({nm, ".frame_err"}, bus.frame_err, 0);
      check({nm, ".err_code"}, bus.err_code, 0);
      check({nm, ".strobes"}, {bus.start, bus.retransmit, bus.clear, bus.clear_interrupt}, 0);
      check({nm, ".push"}, bus.push, 0);
      check({nm, ".push_data"}, bus.push_data, 0);
   endtask

   typedef struct {
      int          n;
      logic [63:0] b;
      logic [1:0]  f;
      logic        bz;
      logic [3:0]  e_n;
      logic        e_ferr;
      logic [1:0]  e_code;
      int          e_st, e_rt, e_cl, e_pu;
   } vec_t;
   vec_t tbl[19];

   logic [7:0]    r_len, r_cmd, r_end;
   logic [7:0]    r_pay[$];
   logic [CH-1:0] r_full[$];
   logic [CH+DW-1:0] eq[$];
   logic          r_bz, r_data, r_ok, r_err;
   logic [3:0]    m_n;
   logic          m_ferr;
   logic [1:0]    m_code;
   int            e_st, e_rt, e_cl, gap;

   initial begin
      bus.rx_interrupt = 1'b0;
      bus.uart_data    = '0;
      bus.full         = '0;
      bus.busy         = 1'b0;

      tbl[0]  = '{5, 64'hFE020105EF000000, 2'b00, 1'b0, 4'd5, 1'b0, 2'd0, 0, 0, 0, 0};
      tbl[1]  = '{7, 64'hFE0411AABBCCEF00, 2'b00, 1'b0, 4'd5, 1'b0, 2'd0, 0, 0, 0, 3};
      tbl[2]  = '{4, 64'hFE0103EF00000000, 2'b00, 1'b0, 4'd5, 1'b0, 2'd0, 1, 0, 0, 0};
      tbl[3]  = '{5, 64'hFE020109EF000000, 2'b00, 1'b0, 4'd5, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[4]  = '{4, 64'hFE0102EF00000000, 2'b00, 1'b0, 4'd5, 1'b0, 2'd1, 0, 1, 0, 0};
      tbl[5]  = '{4, 64'hFE010FEF00000000, 2'b00, 1'b0, 4'd5, 1'b0, 2'd1, 0, 0, 1, 0};
      tbl[6]  = '{4, 64'hFE0103EF00000000, 2'b00, 1'b1, 4'd5, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[7]  = '{4, 64'hFE0110EF00000000, 2'b00, 1'b0, 4'd5, 1'b0, 2'd1, 0, 0, 0, 0};
      tbl[8]  = '{5, 64'hFE021255EF000000, 2'b00, 1'b0, 4'd5, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[9]  = '{5, 64'hFE020108EF000000, 2'b00, 1'b0, 4'd8, 1'b0, 2'd1, 0, 0, 0, 0};
      tbl[10] = '{5, 64'hFE020100EF000000, 2'b00, 1'b0, 4'd8, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[11] = '{5, 64'hFE020131EF000000, 2'b00, 1'b0, 4'd1, 1'b0, 2'd1, 0, 0, 0, 0};
      tbl[12] = '{2, 64'hFE00000000000000, 2'b00, 1'b0, 4'd1, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[13] = '{5, 64'h13FE0102EF000000, 2'b00, 1'b0, 4'd1, 1'b0, 2'd1, 0, 1, 0, 0};
      tbl[14] = '{4, 64'hFE0102AA00000000, 2'b00, 1'b0, 4'd1, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[15] = '{5, 64'hFE021177EF000000, 2'b10, 1'b0, 4'd1, 1'b1, 2'd2, 0, 0, 0, 0};
      tbl[16] = '{4, 64'hFE0101EF00000000, 2'b00, 1'b0, 4'd1, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[17] = '{6, 64'hFE03010505EF0000, 2'b00, 1'b0, 4'd1, 1'b1, 2'd1, 0, 0, 0, 0};
      tbl[18] = '{5, 64'hFE021177EF000000, 2'b01, 1'b0, 4'd1, 1'b0, 2'd1, 0, 0, 0, 1};

      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++) begin
         mark();
         for (int j = 0; j < tbl[i].n; j++)
            send_byte(tbl[i].b[63-8*j -: 8], tbl[i].f, tbl[i].bz, i % 3);
         check_frame($sformatf("vec%0d", i), tbl[i].e_n, tbl[i].e_ferr, tbl[i].e_code,
                     tbl[i].e_st, tbl[i].e_rt, tbl[i].e_cl, tbl[i].n, tbl[i].e_pu);
      end

      // back-to-back data frame: every byte acknowledged and pushed in order
      mark();
      send_byte(8'hFE, 2'b00, 1'b0, 0); send_byte(8'h04, 2'b00, 1'b0, 0);
      send_byte(8'h11, 2'b00, 1'b0, 0); send_byte(8'hAA, 2'b00, 1'b0, 0);
      send_byte(8'hBB, 2'b00, 1'b0, 0); send_byte(8'hCC, 2'b00, 1'b0, 0);
      send_byte(8'hEF, 2'b00, 1'b0, 0);
      check_frame("b2b", 4'd1, 1'b0, 2'd1, 0, 0, 0, 7, 3);
      if (pq.size() >= p0 + 3) begin
         check("b2b.push0", pq[p0],     {2'b10, 8'hAA});
         check("b2b.push1", pq[p0 + 1], {2'b10, 8'hBB});
         check("b2b.push2", pq[p0 + 2], {2'b10, 8'hCC});
      end

      mark();
      send_byte(8'hFE, 2'b00, 1'b0, 1); send_byte(8'h03, 2'b00, 1'b0, 1);
      send_byte(8'h10, 2'b00, 1'b0, 1); send_byte(8'h11, 2'b00, 1'b0, 1);
      send_byte(8'h22, 2'b01, 1'b0, 1); send_byte(8'hEF, 2'b00, 1'b0, 1);
      check_frame("ovf", 4'd1, 1'b1, 2'd2, 0, 0, 0, 6, 1);
      if (pq.size() >= p0 + 1) check("ovf.push0", pq[p0], {2'b01, 8'h11});

      mark();
      send_byte(8'hFE, 2'b00, 1'b0, 15); send_byte(8'h02, 2'b00, 1'b0, 15);
      send_byte(8'h01, 2'b00, 1'b0, 15); send_byte(8'h07, 2'b00, 1'b0, 15);
      send_byte(8'hEF, 2'b00, 1'b0, 0);
      check_frame("tmo_edge", 4'd7, 1'b0, 2'd2, 0, 0, 0, 5, 0);

      mark();
      send_byte(8'hFE, 2'b00, 1'b0, 0); send_byte(8'h02, 2'b00, 1'b0, 0);
      send_byte(8'h01, 2'b00, 1'b0, 16);
      check("tmo.err_code", bus.err_code, 2'd3);
      check("tmo.frame_err", bus.frame_err, 1'b1);
      send_byte(8'h05, 2'b00, 1'b0, 0); send_byte(8'hEF, 2'b00, 1'b0, 0);
      check_frame("tmo_tail", 4'd7, 1'b1, 2'd3, 0, 0, 0, 5, 0);
      mark();
      send_byte(8'hFE, 2'b00, 1'b0, 0); send_byte(8'h01, 2'b00, 1'b0, 0);
      send_byte(8'h02, 2'b00, 1'b0, 0); send_byte(8'hEF, 2'b00, 1'b0, 0);
      check_frame("after_tmo", 4'd7, 1'b0, 2'd3, 0, 1, 0, 4, 0);

      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      m_n = 4'd1; m_ferr = 1'b0; m_code = 2'd0;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 7))
            0: r_cmd = 8'h01;
            1: r_cmd = 8'h02;
            2: r_cmd = 8'h03;
            3: r_cmd = 8'h0F;
            4: r_cmd = 8'h10;
            5: r_cmd = 8'h11;
            6: r_cmd = 8'h12;
            default: r_cmd = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 3) == 0) r_len = 8'($urandom_range(0, 6));
         else if (r_cmd == 8'h01) r_len = 8'd2;
         else if (r_cmd[7:4] == 4'h1) r_len = 8'($urandom_range(1, 6));
         else r_len = 8'd1;
         r_pay.delete(); r_full.delete(); eq.delete();
         for (int i = 1; i < int'(r_len); i++) begin
            r_pay.push_back(8'($urandom_range(0, 255)) & 8'hF0 | 8'($urandom_range(0, 10)));
            r_full.push_back(($urandom_range(0, 3) == 0) ? CH'($urandom_range(0, 3)) : '0);
         end
         r_end = ($urandom_range(0, 7) == 0) ? 8'h5A : 8'hEF;
         r_bz  = 1'($urandom_range(0, 1));
         gap   = $urandom_range(0, 3);

         e_st = 0; e_rt = 0; e_cl = 0; r_err = 1'b0;
         r_data = (r_cmd[7:4] == 4'h1) && (int'(r_cmd[3:0]) < CH);
         if (r_len == 8'd0) begin
            m_code = 2'd1; m_ferr = 1'b1;
         end else begin
            foreach (r_pay[i]) begin
               if (r_data && r_full[i][r_cmd[0]]) begin
                  m_code = 2'd2; m_ferr = 1'b1; r_err = 1'b1;
               end else if (r_data) begin
                  eq.push_back({CH'(1) << r_cmd[3:0], r_pay[i]});
               end
            end
            case (r_cmd)
               8'h01: r_ok = (r_len == 2) && (r_pay[0][3:0] >= 1) && (r_pay[0][3:0] <= MAX_N);
               8'h02, 8'h0F: r_ok = (r_len == 1);
               8'h03: r_ok = (r_len == 1) && !r_bz;
               default: r_ok = r_data;
            endcase
            if (r_end != 8'hEF || !r_ok) begin
               m_code = 2'd1; m_ferr = 1'b1;
            end else begin
               if (!r_err) m_ferr = 1'b0;
               if (r_cmd == 8'h01) m_n = r_pay[0][3:0];
               e_st = int'(r_cmd == 8'h03);
               e_rt = int'(r_cmd == 8'h02);
               e_cl = int'(r_cmd == 8'h0F);
            end
         end

         mark();
         send_byte(8'hFE, '0, r_bz, gap);
         send_byte(r_len, '0, r_bz, gap);
         if (r_len != 8'd0) begin
            send_byte(r_cmd, '0, r_bz, gap);
            foreach (r_pay[i]) send_byte(r_pay[i], r_full[i], r_bz, gap);
            send_byte(r_end, '0, r_bz, gap);
         end
         check_frame($sformatf("rnd%0d", k), m_n, m_ferr, m_code, e_st, e_rt, e_cl,
                     (r_len == 0) ? 2 : int'(r_len) + 3, eq.size());
         foreach (eq[i])
            if (p0 + i < pq.size()) check($sformatf("rnd%0d.push%0d", k, i), pq[p0 + i], eq[i]);
      end

      mark();
      send_byte(8'hFE, 2'b00, 1'b1, 0); send_byte(8'h01, 2'b00, 1'b1, 0);
      send_byte(8'h03, 2'b00, 1'b1, 0); send_byte(8'hEF, 2'b00, 1'b1, 0);
      check_frame("busy", m_n, 1'b1, 2'd1, 0, 0, 0, 4, 0);
      send_byte(8'hFE, 2'b00, 1'b0, 0); send_byte(8'h01, 2'b00, 1'b0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("midrst");
      rst = 1'b0;
      mark();
      send_byte(8'h03, 2'b00, 1'b0, 0); send_byte(8'hEF, 2'b00, 1'b0, 0);
      check_frame("post_rst", 4'd1, 1'b0, 2'd0, 0, 0, 0, 2, 0);

      check("ack_push_timing", lat_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
